// File: rtl/ir_pkg.sv
// Shared types and constants for the IR link scheduler: FSM states,
// NEC burst field positions and default frame timing.
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SENSE  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_TX     = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // NEC burst layout: addr, ~addr, cmd, ~cmd from MSB down.
    localparam int ADDR_HI  = 31;
    localparam int NADDR_HI = 23;
    localparam int CMD_HI   = 15;
    localparam int NCMD_HI  = 7;

    localparam int DEF_FRAME_CYCLES = 6_750_000;
    localparam int DEF_GAP_CYCLES   = 4_000_000;
    localparam int DEF_QUIET_CYCLES = 1_000_000;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module synchronizer #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/ir_link_sched.sv
// Half-duplex IR link scheduler: round-robin arbitration of NEC transmit
// requests with carrier sense, frame/gap timing and rx burst validation.
module ir_link_sched
    import ir_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_cmd,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        tx_addr,
    output logic [7:0]        tx_cmd,
    output logic              tx_send,
    input  logic              rx_line,
    input  logic              rx_ready,
    input  logic [31:0]       rx_burst,
    output logic              rx_valid,
    output logic [7:0]        rx_addr,
    output logic [7:0]        rx_cmd,
    output logic              rx_err,
    output logic              busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int QW   = $clog2(QUIET_CYCLES + 1);
    localparam int FMAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [QW-1:0] QUIET_TERM = QW'(QUIET_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [FW-1:0] GAP_LAST   = FW'(GAP_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   pick;
    logic [NREQ-1:0] win_onehot;
    logic [QW-1:0]   quiet_cnt;
    logic            quiet;
    logic [FW-1:0]   frame_cnt;
    logic            line_sync;
    logic            rx_accept;
    logic            rx_good;

    // First asserted request at or after ptr, wrapping around.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] sel;
        logic [PW-1:0] idx;
        logic          hit;
        sel = ptr;
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!hit && r[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    synchronizer #(
        .SYNC_STAGES(2),
        .RESET_VAL  (1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_line),
        .q    (line_sync)
    );

    // Our own transmission echoes onto the receiver, so never count quiet while talking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_cnt <= '0;
        end else if (!line_sync || state == ST_LAUNCH || state == ST_TX || state == ST_GAP) begin
            quiet_cnt <= '0;
        end else if (quiet_cnt != QUIET_TERM) begin
            quiet_cnt <= quiet_cnt + 1'b1;
        end
    end

    assign quiet = (quiet_cnt == QUIET_TERM);
    assign pick  = rr_pick(req, rr_ptr);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (|req) state_next = ST_SENSE;
            ST_SENSE: begin
                if (!(|req))    state_next = ST_IDLE;
                else if (quiet) state_next = ST_LAUNCH;
            end
            ST_LAUNCH: state_next = ST_TX;
            ST_TX:     if (frame_cnt == FRAME_LAST) state_next = ST_GAP;
            ST_GAP:    if (frame_cnt == GAP_LAST) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Winner and tx bytes latch on entry to LAUNCH so they are valid with tx_send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner    <= '0;
            rr_ptr    <= '0;
            tx_addr   <= '0;
            tx_cmd    <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_SENSE: begin
                    if (state_next == ST_LAUNCH) begin
                        winner  <= pick;
                        tx_addr <= req_addr[{pick, 3'b000} +: 8];
                        tx_cmd  <= req_cmd[{pick, 3'b000} +: 8];
                    end
                end
                ST_LAUNCH: begin
                    frame_cnt <= '0;
                    rr_ptr    <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
                ST_TX: begin
                    frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
                end
                ST_GAP: begin
                    frame_cnt <= (frame_cnt == GAP_LAST) ? '0 : frame_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    assign tx_send = (state == ST_LAUNCH);
    assign gnt     = (state == ST_LAUNCH) ? win_onehot : '0;
    assign done    = (state == ST_GAP && frame_cnt == GAP_LAST) ? win_onehot : '0;
    assign busy    = (state != ST_IDLE);

    assign rx_accept = rx_ready && (state == ST_IDLE || state == ST_SENSE);
    assign rx_good   = (rx_burst[ADDR_HI -: 8] == ~rx_burst[NADDR_HI -: 8]) &&
                       (rx_burst[CMD_HI -: 8]  == ~rx_burst[NCMD_HI -: 8]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_addr  <= '0;
            rx_cmd   <= '0;
        end else begin
            rx_valid <= rx_accept && rx_good;
            rx_err   <= rx_accept && !rx_good;
            if (rx_accept && rx_good) begin
                rx_addr <= rx_burst[ADDR_HI -: 8];
                rx_cmd  <= rx_burst[CMD_HI -: 8];
            end
        end
    end

endmodule

// File: tb/tb_ir_link_sched.sv
// Directed scoreboard bench for ir_link_sched with shortened frame timing.
module tb_ir_link_sched;

    localparam int NREQ  = 4;
    localparam int FRAME = 100;
    localparam int GAP   = 50;
    localparam int QUIET = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_addr = '0;
    logic [8*NREQ-1:0] req_cmd = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        tx_addr;
    logic [7:0]        tx_cmd;
    logic              tx_send;
    logic              rx_line = 1'b1;
    logic              rx_ready = 1'b0;
    logic [31:0]       rx_burst = '0;
    logic              rx_valid;
    logic [7:0]        rx_addr;
    logic [7:0]        rx_cmd;
    logic              rx_err;
    logic              busy;

    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic [7:0] cmd;
    } tx_exp_t;

    typedef struct {
        logic       valid;
        logic       err;
        logic [7:0] addr;
        logic [7:0] cmd;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];
    int checks = 0;
    int errors = 0;

    ir_link_sched #(
        .NREQ        (NREQ),
        .FRAME_CYCLES(FRAME),
        .GAP_CYCLES  (GAP),
        .QUIET_CYCLES(QUIET)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_addr(req_addr),
        .req_cmd (req_cmd),
        .gnt     (gnt),
        .done    (done),
        .tx_addr (tx_addr),
        .tx_cmd  (tx_cmd),
        .tx_send (tx_send),
        .rx_line (rx_line),
        .rx_ready(rx_ready),
        .rx_burst(rx_burst),
        .rx_valid(rx_valid),
        .rx_addr (rx_addr),
        .rx_cmd  (rx_cmd),
        .rx_err  (rx_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus_reset();
        rst_n    = 1'b0;
        req      = '0;
        rx_line  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_bytes(input int i, input logic [7:0] a, input logic [7:0] c);
        req_addr[8*i +: 8] = a;
        req_cmd[8*i +: 8]  = c;
    endtask

    // Counts falling edges until tx_send is seen; -1 if the budget runs out.
    task automatic wait_tx(input int limit, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = (tx_send === 1'b1);
        end
        if (!hit) n = -1;
    endtask

    task automatic wait_done(input int limit, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = (done !== 4'b0000);
        end
        if (!hit) n = -1;
    endtask

    task automatic check_launch();
        tx_exp_t e;
        logic [NREQ-1:0] oh;
        if (tx_q.size() == 0) begin
            check_output("tx_queue_empty", 32'd1, 32'd0);
        end else begin
            e = tx_q.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            check_output("gnt", {28'd0, gnt}, {28'd0, oh});
            check_output("tx_addr", {24'd0, tx_addr}, {24'd0, e.addr});
            check_output("tx_cmd", {24'd0, tx_cmd}, {24'd0, e.cmd});
        end
    endtask

    task automatic check_rx();
        rx_exp_t e;
        if (rx_q.size() == 0) begin
            check_output("rx_queue_empty", 32'd1, 32'd0);
        end else begin
            e = rx_q.pop_front();
            check_output("rx_valid", {31'd0, rx_valid}, {31'd0, e.valid});
            check_output("rx_err", {31'd0, rx_err}, {31'd0, e.err});
            check_output("rx_addr", {24'd0, rx_addr}, {24'd0, e.addr});
            check_output("rx_cmd", {24'd0, rx_cmd}, {24'd0, e.cmd});
        end
    endtask

    initial begin
        int  n;
        int  launch_cycle;
        bit  hit;
        bit  seen;

        // Single requester: reset state, launch timing, done timing, rx in the SENSE->LAUNCH cycle.
        apply_stimulus_reset();
        check_output("reset_ctrl", {22'd0, busy, tx_send, gnt, done},
                     32'd0);
        check_output("reset_data", {tx_addr, tx_cmd, rx_addr, rx_cmd}, 32'd0);
        check_output("reset_rx_pulses", {30'd0, rx_valid, rx_err}, 32'd0);
        set_bytes(0, 8'h10, 8'h01);
        req = 4'b0001;
        tx_q.push_back('{idx: 0, addr: 8'h10, cmd: 8'h01});
        rx_q.push_back('{valid: 1'b1, err: 1'b0, addr: 8'h5A, cmd: 8'h3C});
        rx_burst = 32'h5AA53CC3;
        @(negedge clk);
        rst_n = 1'b1;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 60) begin
            @(negedge clk);
            n++;
            rx_ready = (n == 20);
            hit = (tx_send === 1'b1);
        end
        launch_cycle = hit ? n + 1 : -1;
        check_output("first_launch_cycle", launch_cycle, 22);
        check_rx();
        check_launch();
        check_output("busy_launch", {31'd0, busy}, 32'd1);
        wait_done(300, n);
        check_output("done_delay", n, 150);
        check_output("done_onehot", {28'd0, done}, 32'd1);
        req = '0;
        @(negedge clk);
        check_output("after_done_idle", {27'd0, busy, done}, 32'd0);

        // Round robin with requesters 0, 1 and 3 held.
        apply_stimulus_reset();
        for (int i = 0; i < NREQ; i++) set_bytes(i, 8'hA0 + 8'(i), 8'hC0 + 8'(i));
        req = 4'b1011;
        tx_q.push_back('{idx: 0, addr: 8'hA0, cmd: 8'hC0});
        tx_q.push_back('{idx: 1, addr: 8'hA1, cmd: 8'hC1});
        tx_q.push_back('{idx: 3, addr: 8'hA3, cmd: 8'hC3});
        tx_q.push_back('{idx: 0, addr: 8'hA0, cmd: 8'hC0});
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_tx(400, n);
            if (g > 0) check_output("rr_spacing", {31'd0, n >= 152}, 32'd1);
            else       check_output("rr_first", n, 21);
            check_launch();
        end

        // Carrier sense: a low pulse every 15 cycles holds off the launch.
        apply_stimulus_reset();
        set_bytes(2, 8'h33, 8'h44);
        req = 4'b0100;
        tx_q.push_back('{idx: 2, addr: 8'h33, cmd: 8'h44});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int p = 0; p < 10; p++) begin
            rx_line = 1'b0;
            @(negedge clk);
            rx_line = 1'b1;
            repeat (14) begin
                @(negedge clk);
                if (tx_send === 1'b1) seen = 1'b1;
            end
        end
        check_output("no_launch_while_busy_line", {31'd0, seen}, 32'd0);
        check_output("sensing_busy", {31'd0, busy}, 32'd1);
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        // Raw low captured at the edge just passed, synchronized one edge later,
        // then the quiet window needs QUIET+1 further edges before LAUNCH.
        wait_tx(100, n);
        check_output("launch_after_quiet", n, 23);
        check_launch();

        // Receive path: good burst, bad burst, and a burst dropped during TX.
        apply_stimulus_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.push_back('{valid: 1'b1, err: 1'b0, addr: 8'h10, cmd: 8'h80});
        rx_burst = 32'h10EF807F;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_rx();
        @(negedge clk);
        check_output("rx_valid_one_cycle", {31'd0, rx_valid}, 32'd0);
        rx_q.push_back('{valid: 1'b0, err: 1'b1, addr: 8'h10, cmd: 8'h80});
        rx_burst = 32'h10EF8070;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_rx();
        @(negedge clk);
        check_output("rx_err_one_cycle", {31'd0, rx_err}, 32'd0);
        repeat (25) @(negedge clk);
        set_bytes(0, 8'h10, 8'h01);
        req = 4'b0001;
        tx_q.push_back('{idx: 0, addr: 8'h10, cmd: 8'h01});
        wait_tx(100, n);
        check_output("req_to_send_latency", n, 2);
        check_launch();
        repeat (10) @(negedge clk);
        rx_burst = 32'h22DD44BB;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_output("rx_dropped_in_tx", {30'd0, rx_valid, rx_err}, 32'd0);
        check_output("rx_hold_in_tx", {16'd0, rx_addr, rx_cmd}, 32'h1080);

        // Asynchronous reset in the middle of TX, then a fresh quiet window.
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_ctrl", {22'd0, busy, tx_send, gnt, done}, 32'd0);
        check_output("async_reset_tx_bytes", {16'd0, tx_addr, tx_cmd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_q.push_back('{idx: 0, addr: 8'h10, cmd: 8'h01});
        wait_tx(100, n);
        check_output("relaunch_after_reset", n, 21);
        check_launch();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
